// File: rtl/divconv_pkg.sv
// Shared types for the Goldschmidt div/sqrt sequencer: FSM states,
// operand-mux select codes and the packed control word driven to divconv.
package divconv_pkg;

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        SQ_A = 4'd1,
        IA_D = 4'd2,
        IA_N = 4'd3,
        IT_N = 4'd4,
        IT_K = 4'd5,
        IT_D = 4'd6,
        QGEN = 4'd7,
        REM  = 4'd8,
        DONE = 4'd9
    } state_t;

    // Multiplier A-port sources
    localparam logic [2:0] MUXA_REGC = 3'b000;
    localparam logic [2:0] MUXA_N2   = 3'b001;
    localparam logic [2:0] MUXA_IA   = 3'b010;
    localparam logic [2:0] MUXA_REGB = 3'b011;
    localparam logic [2:0] MUXA_REGD = 3'b100;

    // Multiplier B-port sources
    localparam logic [2:0] MUXB_D2   = 3'b000;
    localparam logic [2:0] MUXB_IA   = 3'b001;
    localparam logic [2:0] MUXB_REGA = 3'b010;
    localparam logic [2:0] MUXB_REGC = 3'b011;
    localparam logic [2:0] MUXB_REGD = 3'b100;
    localparam logic [2:0] MUXB_REGB = 3'b110;

    typedef struct packed {
        logic [2:0] sel_muxa;
        logic [2:0] sel_muxb;
        logic       sel_muxr;
        logic       load_rega;
        logic       load_regb;
        logic       load_regc;
        logic       load_regd;
        logic       load_regr;
        logic       load_regs;
        logic       busy;
        logic       done;
    } ctrl_t;

endpackage

// File: rtl/divconv_ctrl_dec.sv
// Moore output decoder: maps the current state (and the latched operation
// type, which picks the div or sqrt operand routing) to the control word.
module divconv_ctrl_dec
    import divconv_pkg::*;
(
    input  state_t i_state,
    input  logic   i_op_type,
    output ctrl_t  o_ctrl
);

    // Decode state into selects and register loads; unlisted fields stay 0
    always_comb begin
        o_ctrl      = '0;
        o_ctrl.busy = (i_state inside {SQ_A, IA_D, IA_N, IT_N, IT_K, IT_D, QGEN, REM, DONE});
        case (i_state)
            SQ_A: begin
                o_ctrl.sel_muxa  = MUXA_IA;
                o_ctrl.sel_muxb  = MUXB_IA;
                o_ctrl.load_rega = 1'b1;
            end
            IA_D: begin
                o_ctrl.sel_muxa  = i_op_type ? MUXA_N2   : MUXA_IA;
                o_ctrl.sel_muxb  = i_op_type ? MUXB_REGA : MUXB_D2;
                o_ctrl.load_regc = 1'b1;
                o_ctrl.load_regd = 1'b1;
            end
            IA_N: begin
                o_ctrl.sel_muxa  = MUXA_N2;
                o_ctrl.sel_muxb  = MUXB_IA;
                o_ctrl.load_regb = 1'b1;
            end
            IT_N: begin
                o_ctrl.sel_muxa  = MUXA_REGC;
                o_ctrl.sel_muxb  = MUXB_REGB;
                o_ctrl.load_regb = 1'b1;
            end
            IT_K: begin
                o_ctrl.sel_muxa  = MUXA_REGC;
                o_ctrl.sel_muxb  = MUXB_REGC;
                o_ctrl.load_rega = 1'b1;
            end
            IT_D: begin
                o_ctrl.sel_muxa  = i_op_type ? MUXA_REGD : MUXA_REGC;
                o_ctrl.sel_muxb  = i_op_type ? MUXB_REGA : MUXB_REGD;
                o_ctrl.load_regc = 1'b1;
                o_ctrl.load_regd = 1'b1;
            end
            QGEN: o_ctrl.load_regs = 1'b1;
            REM: begin
                o_ctrl.sel_muxr  = 1'b1;
                o_ctrl.load_regr = 1'b1;
            end
            DONE: o_ctrl.done = 1'b1;
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/divconv_ctrl.sv
// Goldschmidt div/sqrt sequencer. Accepts a start in IDLE, latches the
// operation, then walks the initial-approximation, iteration, quotient and
// remainder steps. Outputs are a pure function of the state register.
module divconv_ctrl
    import divconv_pkg::*;
#(
    parameter int ITERS_DP = 3,
    parameter int ITERS_SP = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       flush,
    input  logic       op_type_i,
    input  logic       p_i,
    input  logic       exp_odd_i,
    output logic       op_type,
    output logic       P,
    output logic       exp_odd,
    output logic [2:0] sel_muxa,
    output logic [2:0] sel_muxb,
    output logic       sel_muxr,
    output logic       load_rega,
    output logic       load_regb,
    output logic       load_regc,
    output logic       load_regd,
    output logic       load_regr,
    output logic       load_regs,
    output logic       busy,
    output logic       done
);

    localparam int CNT_W = $clog2((ITERS_DP > ITERS_SP ? ITERS_DP : ITERS_SP) + 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_iter_cnt;
    logic             r_op_type;
    logic             r_p;
    logic             r_exp_odd;
    logic             w_accept;
    ctrl_t            w_ctrl;

    // flush wins over start, so a flushed IDLE cycle never accepts
    assign w_accept = (r_state == IDLE) && start && !flush;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Latch the operation on accept; count remaining N updates in IT_N
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_iter_cnt <= '0;
            r_op_type  <= 1'b0;
            r_p        <= 1'b0;
            r_exp_odd  <= 1'b0;
        end else if (w_accept) begin
            r_op_type  <= op_type_i;
            r_p        <= p_i;
            r_exp_odd  <= exp_odd_i;
            r_iter_cnt <= p_i ? CNT_W'(ITERS_SP) : CNT_W'(ITERS_DP);
        end else if (r_state == IT_N) begin
            r_iter_cnt <= r_iter_cnt - CNT_W'(1);
        end
    end

    // Next-state sequencing; sqrt inserts SQ_A up front and IT_K per iteration
    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (start) w_next = op_type_i ? SQ_A : IA_D;
                SQ_A:    w_next = IA_D;
                IA_D:    w_next = IA_N;
                IA_N:    w_next = IT_N;
                IT_N:    if (r_iter_cnt == CNT_W'(1)) w_next = QGEN;
                         else                         w_next = r_op_type ? IT_K : IT_D;
                IT_K:    w_next = IT_D;
                IT_D:    w_next = IT_N;
                QGEN:    w_next = REM;
                REM:     w_next = DONE;
                DONE:    w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    divconv_ctrl_dec u_dec (
        .i_state   (r_state),
        .i_op_type (r_op_type),
        .o_ctrl    (w_ctrl)
    );

    assign op_type   = r_op_type;
    assign P         = r_p;
    assign exp_odd   = r_exp_odd;
    assign sel_muxa  = w_ctrl.sel_muxa;
    assign sel_muxb  = w_ctrl.sel_muxb;
    assign sel_muxr  = w_ctrl.sel_muxr;
    assign load_rega = w_ctrl.load_rega;
    assign load_regb = w_ctrl.load_regb;
    assign load_regc = w_ctrl.load_regc;
    assign load_regd = w_ctrl.load_regd;
    assign load_regr = w_ctrl.load_regr;
    assign load_regs = w_ctrl.load_regs;
    assign busy      = w_ctrl.busy;
    assign done      = w_ctrl.done;

endmodule
